uart_rx_ctrl: RTL and testbench

//   Receive-side sequencer for the UART. Oversamples the serial line, confirms the start bit,

---
 rtl/uart_rx_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: 2-flop synchroniser, start-bit qualification, mid-bit sampling,
// valid/ready byte output with framing/parity/overrun pulses. Parity via `UART_RX_PARITY_EN.
//
// state   | meaning
// IDLE    | line high, waiting for a falling edge
// START   | qualifying start bit for CLKS_PER_BIT/2 low cycles
// DATA    | sampling data bits LSB first at mid-bit
// PARITY  | sampling parity bit (only with UART_RX_PARITY_EN)
// STOP    | sampling stop bit
// DONE    | one cycle: hand byte to output register or flag overrun
// BREAK   | stop bit was low; wait for the line to return high
module uart_rx_ctrl #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 RX_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
`ifdef UART_RX_PARITY_EN
   input  logic                 parity_odd,
`endif
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_DONE,
      S_BREAK
`ifdef UART_RX_PARITY_EN
      , S_PARITY
`endif
   } state_t;

   logic                 r_sync1;
   logic                 r_sync2;
   logic                 w_rxs;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CW-1:0]        r_clk_cnt;
   logic [CW-1:0]        w_clk_cnt_nxt;
   logic [2:0]           r_bit_idx;
   logic [2:0]           w_bit_idx_nxt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_shift_nxt;
   logic [DATA_BITS-1:0] r_rx_data;
   logic [DATA_BITS-1:0] w_rx_data_nxt;
   logic                 r_rx_valid;
   logic                 w_rx_valid_nxt;
   logic                 r_frame_err;
   logic                 w_frame_err_nxt;
   logic                 r_overrun;
   logic                 w_overrun_nxt;
`ifdef UART_RX_PARITY_EN
   logic                 r_par_bad;
   logic                 w_par_bad_nxt;
   logic                 r_parity_err;
   logic                 w_parity_err_nxt;
`endif

   // Synchroniser resets to the idle-high line level so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= RX_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rxs = r_sync2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_clk_cnt   <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bad    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_clk_cnt   <= w_clk_cnt_nxt;
         r_bit_idx   <= w_bit_idx_nxt;
         r_shift     <= w_shift_nxt;
         r_rx_data   <= w_rx_data_nxt;
         r_rx_valid  <= w_rx_valid_nxt;
         r_frame_err <= w_frame_err_nxt;
         r_overrun   <= w_overrun_nxt;
`ifdef UART_RX_PARITY_EN
         r_par_bad    <= w_par_bad_nxt;
         r_parity_err <= w_parity_err_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_clk_cnt_nxt   = r_clk_cnt;
      w_bit_idx_nxt   = r_bit_idx;
      w_shift_nxt     = r_shift;
      w_rx_data_nxt   = r_rx_data;
      w_rx_valid_nxt  = r_rx_valid & ~rx_ready;
      w_frame_err_nxt = 1'b0;
      w_overrun_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_bad_nxt    = r_par_bad;
      w_parity_err_nxt = 1'b0;
`endif

      case (r_state)
         S_IDLE: begin
            w_clk_cnt_nxt = '0;
            if (!w_rxs) begin
               // The falling-edge cycle itself is the first qualifying low sample.
               w_state_nxt   = S_START;
               w_clk_cnt_nxt = CW'(1);
            end
         end

         S_START: begin
            if (w_rxs) begin
               w_state_nxt   = S_IDLE;
               w_clk_cnt_nxt = '0;
            end else if (r_clk_cnt == CNT_HALF) begin
               w_state_nxt   = S_DATA;
               w_clk_cnt_nxt = '0;
               w_bit_idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
               w_par_bad_nxt = 1'b0;
`endif
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + CW'(1);
            end
         end

         S_DATA: begin
            if (r_clk_cnt == CNT_LAST) begin
               w_clk_cnt_nxt = '0;
               w_bit_idx_nxt = r_bit_idx + 3'd1;
               for (int i = 0; i < DATA_BITS; i++) begin
                  if (r_bit_idx == 3'(i)) w_shift_nxt[i] = w_rxs;
               end
               if (r_bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                  w_state_nxt = S_PARITY;
`else
                  w_state_nxt = S_STOP;
`endif
               end
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + CW'(1);
            end
         end

`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (r_clk_cnt == CNT_LAST) begin
               w_clk_cnt_nxt = '0;
               w_par_bad_nxt = (^r_shift) ^ w_rxs ^ parity_odd;
               w_state_nxt   = S_STOP;
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + CW'(1);
            end
         end
`endif

         S_STOP: begin
            if (r_clk_cnt == CNT_LAST) begin
               w_clk_cnt_nxt = '0;
               if (w_rxs) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_frame_err_nxt = 1'b1;
                  w_state_nxt     = S_BREAK;
               end
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + CW'(1);
            end
         end

         S_DONE: begin
            // A same-cycle accept frees the output register, so the new byte is not an overrun.
            if (!r_rx_valid || rx_ready) begin
               w_rx_data_nxt  = r_shift;
               w_rx_valid_nxt = 1'b1;
            end else begin
               w_overrun_nxt = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            w_parity_err_nxt = r_par_bad;
`endif
            w_state_nxt = S_IDLE;
         end

         S_BREAK: begin
            w_clk_cnt_nxt = '0;
            if (w_rxs) w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt   = S_IDLE;
            w_clk_cnt_nxt = '0;
         end
      endcase
   end

   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
   assign busy      = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err = r_parity_err;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: directed scenarios plus random frames, with a monitor
// that pops expected bytes on each accepted handshake and counts error pulses.
module tb_uart_rx_ctrl;

   localparam int CPB = 16;
   localparam int DB  = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          RX_in = 1'b1;
   logic          rx_ready = 1'b1;
   logic          parity_odd = 1'b0;
   logic [DB-1:0] rx_data;
   logic          rx_valid;
   logic          frame_err;
   logic          parity_err;
   logic          overrun;
   logic          busy;

   int            checks = 0;
   int            errors = 0;
   logic [7:0]    exp_q[$];
   int            fe_cnt = 0;
   int            pe_cnt = 0;
   int            ov_cnt = 0;
   int            got_cnt = 0;
   int            exp_fe = 0;
   int            exp_pe = 0;
   int            exp_got = 0;
   logic          par_bit = 1'b0;

   uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .RX_in      (RX_in),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
`ifdef UART_RX_PARITY_EN
      .parity_odd (parity_odd),
`endif
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic v);
      RX_in = v;
      cyc(CPB);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_v);
      send_bit(1'b0);
      for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(par_bit);
`endif
      send_bit(stop_v);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 2000) begin
         cyc(1);
         n++;
      end
      chk(name, {31'd0, busy}, 32'd0);
   endtask

   // Monitor: samples on the falling edge, away from the DUT's active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (frame_err)  fe_cnt++;
            if (parity_err) pe_cnt++;
            if (overrun)    ov_cnt++;
            if (rx_valid && rx_ready) begin
               got_cnt++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_byte actual=%0h required=none", rx_data);
               end else begin
                  chk("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
               end
            end
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      logic       stop_ok;

      rst_n = 1'b0;
      cyc(3);
      chk("rst_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_data", {24'd0, rx_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_errs", {29'd0, frame_err, parity_err, overrun}, 32'd0);
      rst_n = 1'b1;
      cyc(2);

      // Clean frame
      d = 8'hA5;
      par_bit = (^d) ^ parity_odd;
      exp_q.push_back(d);
      exp_got++;
      send_frame(d, 1'b1);
      cyc(4);
      wait_idle("a5_idle");
      chk("a5_got", got_cnt, exp_got);
      chk("a5_fe", fe_cnt, 0);
      chk("a5_ov", ov_cnt, 0);

      // Short glitch
      RX_in = 1'b0;
      cyc(5);
      RX_in = 1'b1;
      cyc(40);
      chk("glitch_busy", {31'd0, busy}, 32'd0);
      chk("glitch_got", got_cnt, exp_got);
      chk("glitch_fe", fe_cnt, 0);

      // Framing error with line held low afterwards
      d = 8'h3C;
      par_bit = (^d) ^ parity_odd;
      send_frame(d, 1'b0);
      cyc(40);
      exp_fe++;
      chk("break_fe", fe_cnt, exp_fe);
      chk("break_busy", {31'd0, busy}, 32'd1);
      chk("break_got", got_cnt, exp_got);
      RX_in = 1'b1;
      cyc(4);
      wait_idle("break_idle");
      chk("break_fe_once", fe_cnt, exp_fe);

      // Overrun with consumer stalled
      rx_ready = 1'b0;
      d = 8'h11;
      par_bit = (^d) ^ parity_odd;
      exp_q.push_back(d);
      exp_got++;
      send_frame(d, 1'b1);
      cyc(20);
      chk("ov_valid1", {31'd0, rx_valid}, 32'd1);
      chk("ov_data1", {24'd0, rx_data}, 32'h11);
      d = 8'h22;
      par_bit = (^d) ^ parity_odd;
      send_frame(d, 1'b1);
      cyc(20);
      chk("ov_cnt", ov_cnt, 1);
      chk("ov_data2", {24'd0, rx_data}, 32'h11);
      chk("ov_valid2", {31'd0, rx_valid}, 32'd1);
      rx_ready = 1'b1;
      cyc(2);
      chk("ov_drop", {31'd0, rx_valid}, 32'd0);
      chk("ov_got", got_cnt, exp_got);

      // Reset in the middle of data bit 4
      d = 8'h5A;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(d[i]);
      RX_in = d[4];
      cyc(8);
      rst_n = 1'b0;
      #1;
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      chk("mrst_valid", {31'd0, rx_valid}, 32'd0);
      chk("mrst_data", {24'd0, rx_data}, 32'd0);
      RX_in = 1'b1;
      cyc(3);
      rst_n = 1'b1;
      cyc(3);
      par_bit = (^d) ^ parity_odd;
      exp_q.push_back(d);
      exp_got++;
      send_frame(d, 1'b1);
      cyc(4);
      wait_idle("mrst_idle");
      chk("mrst_got", got_cnt, exp_got);

`ifdef UART_RX_PARITY_EN
      // Even parity, wrong parity bit: byte still delivered, parity_err pulses
      parity_odd = 1'b0;
      d = 8'h07;
      par_bit = 1'b0;
      exp_q.push_back(d);
      exp_got++;
      exp_pe++;
      send_frame(d, 1'b1);
      cyc(4);
      wait_idle("par_idle");
      chk("par_pe", pe_cnt, exp_pe);
      chk("par_got", got_cnt, exp_got);
`endif

      // Random frames, occasional bad stop bits and consumer stalls
      for (int n = 0; n < 24; n++) begin
         d = 8'($urandom);
         stop_ok = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
         parity_odd = 1'($urandom_range(0, 1));
`endif
         par_bit = (^d) ^ parity_odd;
         if (stop_ok) begin
            exp_q.push_back(d);
            exp_got++;
         end else begin
            exp_fe++;
         end
         rx_ready = 1'($urandom_range(0, 1));
         send_frame(d, stop_ok);
         if (!stop_ok) begin
            cyc($urandom_range(1, 20));
            RX_in = 1'b1;
         end
         cyc($urandom_range(2, 30));
         rx_ready = 1'b1;
         cyc(2);
         wait_idle("rnd_idle");
      end

      cyc(10);
      chk("end_fe", fe_cnt, exp_fe);
      chk("end_pe", pe_cnt, exp_pe);
      chk("end_ov", ov_cnt, 1);
      chk("end_got", got_cnt, exp_got);
      chk("end_q_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
